alu_op_sequencer: RTL and testbench

- Multi-cycle operation sequencer in front of the 32-bit ALU.
- Accepts one operation at a time over a valid/ready request channel.
- Single-cycle operations (logic, add/sub, shift/rotate) are dispatched to the external combinational ALU through registered operand/opcode outputs.
- MUL/DIV/REM run on an internal iterative shift-add / restoring-divide engine; results return over a valid/ready response channel.

---
 rtl/alu_op_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operation sequencer in front of a combinational 32-bit ALU.
// Single-cycle ops are dispatched to the ALU; MUL/DIV/REM run on an internal iterative engine.
module alu_op_sequencer #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_opcode,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [XLEN-1:0] rsp_hi,
    output logic            rsp_dbz,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result
);

    typedef enum logic [2:0] {IDLE, EXEC, ITER_MUL, ITER_DIV, DONE} state_t;

    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd6;
    localparam logic [3:0] OP_REM  = 4'd7;
    localparam logic [3:0] OP_NONE = 4'hF;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_result_q, rsp_result_d;
    logic [XLEN-1:0]     rsp_hi_q, rsp_hi_d;
    logic                rsp_dbz_q, rsp_dbz_d;
    logic [XLEN-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]          alu_opcode_q, alu_opcode_d;

    // Multiply: acc = {partial high word, remaining multiplier bits}, shifted right each step.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [XLEN:0]       div_shift;
    logic                div_ge;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   div_next;
    logic                last_iter;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
        last_iter = (cnt_q == 6'd31);
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_hi_d     = rsp_hi_q;
        rsp_dbz_d    = rsp_dbz_q;
        // ALU inputs are parked at a known idle value unless this cycle is EXEC.
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_opcode_d = OP_NONE;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_opcode;
                    a_d         = req_a;
                    b_d         = req_b;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    if (req_opcode == OP_MUL) begin
                        state_d = ITER_MUL;
                        acc_d   = {{XLEN{1'b0}}, req_b};
                    end else if (req_opcode == OP_DIV || req_opcode == OP_REM) begin
                        state_d = ITER_DIV;
                        acc_d   = {{XLEN{1'b0}}, req_a};
                    end else begin
                        state_d      = EXEC;
                        alu_a_d      = req_a;
                        alu_b_d      = req_b;
                        alu_opcode_d = req_opcode;
                    end
                end
            end
            EXEC: begin
                state_d      = DONE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_result;
                rsp_hi_d     = '0;
                rsp_dbz_d    = 1'b0;
            end
            ITER_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    state_d      = DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = mul_next[XLEN-1:0];
                    rsp_hi_d     = mul_next[2*XLEN-1:XLEN];
                    rsp_dbz_d    = 1'b0;
                end
            end
            ITER_DIV: begin
                if (b_q == '0) begin
                    state_d      = DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_dbz_d    = 1'b1;
                    rsp_result_d = (op_q == OP_REM) ? a_q : DIV_ZERO_Q;
                    rsp_hi_d     = (op_q == OP_REM) ? DIV_ZERO_Q : a_q;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 6'd1;
                    if (last_iter) begin
                        state_d      = DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_dbz_d    = 1'b0;
                        rsp_result_d = (op_q == OP_REM) ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
                        rsp_hi_d     = (op_q == OP_REM) ? div_next[XLEN-1:0] : div_next[2*XLEN-1:XLEN];
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_hi_q     <= '0;
            rsp_dbz_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= OP_NONE;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_hi_q     <= rsp_hi_d;
            rsp_dbz_q    <= rsp_dbz_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_dbz    = rsp_dbz_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: expected responses are queued at issue
// and compared by a monitor when the response handshake occurs.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result, rsp_hi;
    logic        rsp_dbz;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_hi     (rsp_hi),
        .rsp_dbz    (rsp_dbz),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result)
    );

    // External combinational ALU; unlisted opcodes return 0.
    always_comb begin
        alu_result = 32'h0;
        case (alu_opcode)
            4'd0:  alu_result = alu_a & alu_b;
            4'd1:  alu_result = alu_a | alu_b;
            4'd2:  alu_result = alu_a ^ alu_b;
            4'd3:  alu_result = alu_a + alu_b;
            4'd4:  alu_result = alu_a - alu_b;
            4'd8:  alu_result = alu_a << alu_b[4:0];
            4'd9:  alu_result = alu_a >> alu_b[4:0];
            4'd10: alu_result = (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}));
            4'd11: alu_result = (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}));
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic [31:0] hi, input logic dbz);
        exp_t e;
        e.res = res;
        e.hi  = hi;
        e.dbz = dbz;
        return e;
    endfunction

    // Scoreboard monitor: compares at the sample point of each response handshake.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", 64'(rsp_result), 64'(e.res));
                check("rsp_hi", 64'(rsp_hi), 64'(e.hi));
                check("rsp_dbz", 64'(rsp_dbz), 64'(e.dbz));
            end
        end
    end

    // Called just after a rising edge with the sequencer idle; returns #1 into cycle T+1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input exp_t e);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'(1));
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
    endtask

    // Counts cycles from T+1 until rsp_valid; leaves at the sample point of the response cycle.
    task automatic wait_rsp(input int exp_lat, input string tag);
        int  n    = 1;
        bit  seen = 1'b0;
        while (n <= 60 && !seen) begin
            @(negedge clk);
            check({tag, "_busy_req_ready"}, 64'(req_ready), 64'(0));
            if (rsp_valid) seen = 1'b1;
            else n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] prod;
        bit          stray;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_opcode = 4'd0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        rsp_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        check("rst_rsp_hi", 64'(rsp_hi), 64'(0));
        check("rst_rsp_dbz", 64'(rsp_dbz), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        check("rst_alu_b", 64'(alu_b), 64'(0));
        check("rst_alu_opcode", 64'(alu_opcode), 64'(4'hF));
        next_cycle();
        reset = 1'b0;

        // ADD dispatched through the external ALU
        issue(4'd3, 32'h5, 32'h3, 1'b1, mk(32'd8, 32'd0, 1'b0));
        check("add_alu_opcode", 64'(alu_opcode), 64'(3));
        check("add_alu_a", 64'(alu_a), 64'(5));
        check("add_alu_b", 64'(alu_b), 64'(3));
        wait_rsp(2, "add");
        next_cycle();
        check("idle_alu_opcode", 64'(alu_opcode), 64'(4'hF));

        // MUL full-width operand
        issue(4'd5, 32'hFFFF_FFFF, 32'h2, 1'b1, mk(32'hFFFF_FFFE, 32'h1, 1'b0));
        check("mul_alu_opcode", 64'(alu_opcode), 64'(4'hF));
        wait_rsp(33, "mul");
        next_cycle();

        issue(4'd6, 32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 1'b0));
        wait_rsp(33, "div");
        next_cycle();
        issue(4'd7, 32'd100, 32'd7, 1'b1, mk(32'd2, 32'd14, 1'b0));
        wait_rsp(33, "rem");
        next_cycle();

        issue(4'd6, 32'h1234, 32'h0, 1'b1, mk(32'hFFFF_FFFF, 32'h1234, 1'b1));
        wait_rsp(2, "div_dbz");
        next_cycle();
        issue(4'd7, 32'h55, 32'h0, 1'b1, mk(32'h55, 32'hFFFF_FFFF, 1'b1));
        wait_rsp(2, "rem_dbz");
        next_cycle();

        issue(4'd4, 32'd3, 32'd5, 1'b1, mk(32'hFFFF_FFFE, 32'd0, 1'b0));
        wait_rsp(2, "sub");
        next_cycle();
        issue(4'd10, 32'h8000_0001, 32'd4, 1'b1, mk(32'h0000_0018, 32'd0, 1'b0));
        wait_rsp(2, "rol");
        next_cycle();
        issue(4'd9, 32'h8000_0000, 32'd31, 1'b1, mk(32'h1, 32'd0, 1'b0));
        wait_rsp(2, "shr");
        next_cycle();
        issue(4'd13, 32'hDEAD_BEEF, 32'h1, 1'b1, mk(32'h0, 32'd0, 1'b0));
        wait_rsp(2, "reserved");
        next_cycle();

        for (int i = 0; i < 3; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            prod = 64'(ra) * 64'(rb);
            issue(4'd5, ra, rb, 1'b1, mk(prod[31:0], prod[63:32], 1'b0));
            wait_rsp(33, "mul_rand");
            next_cycle();
            ra = $urandom;
            rb = (i == 0) ? 32'(($urandom % 1000) + 1) : ($urandom | 32'h1);
            issue(4'd6, ra, rb, 1'b1, mk(ra / rb, ra % rb, 1'b0));
            wait_rsp(33, "div_rand");
            next_cycle();
        end

        // Backpressure with a request queued behind the held response
        rsp_ready = 1'b0;
        issue(4'd2, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, mk(32'h0F0F_F0F0, 32'd0, 1'b0));
        wait_rsp(2, "xor");
        req_valid  = 1'b1;
        req_opcode = 4'd3;
        req_a      = 32'd1;
        req_b      = 32'd2;
        sb.push_back(mk(32'd3, 32'd0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            check("bp_rsp_result", 64'(rsp_result), 64'(32'h0F0F_F0F0));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_req_ready", 64'(req_ready), 64'(0));
        next_cycle();
        @(negedge clk);
        check("bp_idle_req_ready", 64'(req_ready), 64'(1));
        check("bp_idle_rsp_valid", 64'(rsp_valid), 64'(0));
        next_cycle();
        req_valid = 1'b0;
        check("queued_alu_opcode", 64'(alu_opcode), 64'(3));
        wait_rsp(2, "queued_add");
        next_cycle();

        // Reset in the middle of a MUL
        issue(4'd5, 32'd3, 32'd4, 1'b0, mk(32'd0, 32'd0, 1'b0));
        repeat (9) next_cycle();
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        check("midrst_alu_opcode", 64'(alu_opcode), 64'(4'hF));
        next_cycle();
        reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) stray = 1'b1;
        end
        check("midrst_no_rsp", 64'(stray), 64'(0));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
